// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selectors, opcodes and the scoreboard entry record.
package cpu_types_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned STALL_W = 16;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDIU = 6'b001001,
        LW    = 6'b100011,
        SW    = 6'b101011
    } opcode_t;

    typedef struct packed {
        logic     valid;
        regbits_t wsel;
        logic     load;
    } sb_entry_t;

    // Jumps carry only an immediate target, so they read no source registers.
    function automatic logic is_jump_op(opcode_t op);
        return (op == J) || (op == JAL);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/scoreboard bundle: decode-stage instruction fields in, stall/redirect controls out.
interface hazard_scoreboard_if #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned DEPTH = 3
);
    import cpu_types_pkg::*;

    logic [$clog2(NREGS)-1:0] id_rsel1;
    logic [$clog2(NREGS)-1:0] id_rsel2;
    logic [$clog2(NREGS)-1:0] id_wsel;
    logic                     id_wen;
    logic                     id_load;
    logic                     id_valid;
    opcode_t                  id_op;
    logic                     id_equal;
    logic                     mem_wait;

    logic                     hazard;
    logic                     branch;
    logic                     jump;
    logic                     flush;
    logic [$clog2(DEPTH+1)-1:0] pending_cnt;
    logic [STALL_W-1:0]       stall_cycles;

    modport master (
        output id_rsel1, id_rsel2, id_wsel, id_wen, id_load, id_valid, id_op, id_equal,
               mem_wait,
        input  hazard, branch, jump, flush, pending_cnt, stall_cycles
    );

    modport slave (
        input  id_rsel1, id_rsel2, id_wsel, id_wen, id_load, id_valid, id_op, id_equal,
               mem_wait,
        output hazard, branch, jump, flush, pending_cnt, stall_cycles
    );

endinterface

// File: rtl/hazard_match.sv
// Compares one decode source register against every in-flight scoreboard entry.
module hazard_match
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH  = 3,
    parameter bit          FWD_EN = 1'b1
) (
    input  regbits_t                    rsel_i,
    input  sb_entry_t [DEPTH-1:0]       entries_i,
    output logic                        match_o
);

    // With forwarding only a load still in the youngest slot cannot be bypassed.
    always_comb begin
        match_o = 1'b0;
        if (rsel_i != '0) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (entries_i[i].valid && (entries_i[i].wsel == rsel_i)) begin
                    if (!FWD_EN || ((i == 0) && entries_i[i].load)) begin
                        match_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks pending register writes and drives stall/redirect.
module hazard_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned DEPTH  = 3,
    parameter bit          FWD_EN = 1'b1
) (
    input logic                CLK,
    input logic                nRST,
    hazard_scoreboard_if.slave sb
);

    localparam int unsigned SEL_W = $clog2(NREGS);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] entries_q;
    sb_entry_t [DEPTH-1:0] entries_d;
    logic [STALL_W-1:0]    stall_cycles_q;
    logic [STALL_W-1:0]    stall_cycles_d;
    logic [CNT_W-1:0]      pending_cnt;

    logic [SEL_W-1:0] id_rsel1;
    logic [SEL_W-1:0] id_rsel2;
    logic [SEL_W-1:0] id_wsel;
    regbits_t         rsel1;
    regbits_t         rsel2;
    regbits_t         wsel;

    logic match1;
    logic match2;
    logic is_jump;
    logic hazard;
    logic branch;
    logic flush;
    logic issue;

    assign id_rsel1 = sb.id_rsel1;
    assign id_rsel2 = sb.id_rsel2;
    assign id_wsel  = sb.id_wsel;
    assign rsel1    = regbits_t'(id_rsel1);
    assign rsel2    = regbits_t'(id_rsel2);
    assign wsel     = regbits_t'(id_wsel);

    hazard_match #(
        .DEPTH  (DEPTH),
        .FWD_EN (FWD_EN)
    ) u_match1 (
        .rsel_i    (rsel1),
        .entries_i (entries_q),
        .match_o   (match1)
    );

    hazard_match #(
        .DEPTH  (DEPTH),
        .FWD_EN (FWD_EN)
    ) u_match2 (
        .rsel_i    (rsel2),
        .entries_i (entries_q),
        .match_o   (match2)
    );

    // Stall and redirect decisions, zero-latency from decode inputs and pre-edge state.
    always_comb begin
        is_jump = is_jump_op(sb.id_op);
        hazard  = sb.id_valid && !is_jump && (match1 || match2);
        branch  = !hazard && (((sb.id_op == BEQ) && sb.id_equal) ||
                              ((sb.id_op == BNE) && !sb.id_equal));
        flush   = (branch || is_jump) && !sb.mem_wait;
        // A stalled or squashed slot must not claim a scoreboard entry; r0 is never tracked.
        issue   = sb.id_valid && sb.id_wen && (wsel != '0) && !hazard && !flush;
    end

    // Population count of in-flight writes.
    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            pending_cnt = pending_cnt + CNT_W'(entries_q[i].valid);
        end
    end

    // Shift the pipeline image one stage older unless memory freezes the pipe.
    always_comb begin
        entries_d      = entries_q;
        stall_cycles_d = stall_cycles_q;
        if (!sb.mem_wait) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                entries_d[i] = entries_q[i-1];
            end
            entries_d[0] = '0;
            if (issue) begin
                entries_d[0] = '{valid: 1'b1, wsel: wsel, load: sb.id_load};
            end
            if (hazard && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + STALL_W'(1);
            end
        end
    end

    // State register; reset drops every in-flight entry at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            entries_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            entries_q      <= entries_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb.hazard       = hazard;
    assign sb.branch       = branch;
    assign sb.jump         = is_jump;
    assign sb.flush        = flush;
    assign sb.pending_cnt  = pending_cnt;
    assign sb.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_hazard_scoreboard;
    import cpu_types_pkg::*;

    logic clk;
    logic nrst;
    logic sample_req;

    // dut 0: forwarding, depth 3; dut 1: no forwarding, depth 3; dut 2: no forwarding, depth 8
    hazard_scoreboard_if #(.NREGS(32), .DEPTH(3)) sb0 ();
    hazard_scoreboard_if #(.NREGS(32), .DEPTH(3)) sb1 ();
    hazard_scoreboard_if #(.NREGS(32), .DEPTH(8)) sb2 ();

    hazard_scoreboard #(.NREGS(32), .DEPTH(3), .FWD_EN(1'b1)) u_dut0 (
        .CLK (clk), .nRST (nrst), .sb (sb0)
    );
    hazard_scoreboard #(.NREGS(32), .DEPTH(3), .FWD_EN(1'b0)) u_dut1 (
        .CLK (clk), .nRST (nrst), .sb (sb1)
    );
    hazard_scoreboard #(.NREGS(32), .DEPTH(8), .FWD_EN(1'b0)) u_dut2 (
        .CLK (clk), .nRST (nrst), .sb (sb2)
    );

    typedef struct {
        int    dut;
        string name;
        logic  hazard;
        logic  branch;
        logic  jump;
        logic  flush;
        int    pend;
        int    stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int d, input string name, input logic h, input logic b,
                        input logic j, input logic f, input int p, input int s);
        exp_t e;
        e.dut = d; e.name = name; e.hazard = h; e.branch = b; e.jump = j; e.flush = f;
        e.pend = p; e.stall = s;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int d, input opcode_t op, input logic v, input logic wen,
                         input logic ld, input int rs1, input int rs2, input int wd,
                         input logic eq, input logic mw);
        case (d)
            0: begin
                sb0.id_op = op; sb0.id_valid = v; sb0.id_wen = wen; sb0.id_load = ld;
                sb0.id_rsel1 = rs1[4:0]; sb0.id_rsel2 = rs2[4:0]; sb0.id_wsel = wd[4:0];
                sb0.id_equal = eq; sb0.mem_wait = mw;
            end
            1: begin
                sb1.id_op = op; sb1.id_valid = v; sb1.id_wen = wen; sb1.id_load = ld;
                sb1.id_rsel1 = rs1[4:0]; sb1.id_rsel2 = rs2[4:0]; sb1.id_wsel = wd[4:0];
                sb1.id_equal = eq; sb1.mem_wait = mw;
            end
            default: begin
                sb2.id_op = op; sb2.id_valid = v; sb2.id_wen = wen; sb2.id_load = ld;
                sb2.id_rsel1 = rs1[4:0]; sb2.id_rsel2 = rs2[4:0]; sb2.id_wsel = wd[4:0];
                sb2.id_equal = eq; sb2.mem_wait = mw;
            end
        endcase
    endtask

    task automatic idle(input int d);
        drive(d, RTYPE, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void get_out(input int d, output logic h, output logic b,
                                    output logic j, output logic f, output int p,
                                    output int s);
        case (d)
            0: begin
                h = sb0.hazard; b = sb0.branch; j = sb0.jump; f = sb0.flush;
                p = int'(sb0.pending_cnt); s = int'(sb0.stall_cycles);
            end
            1: begin
                h = sb1.hazard; b = sb1.branch; j = sb1.jump; f = sb1.flush;
                p = int'(sb1.pending_cnt); s = int'(sb1.stall_cycles);
            end
            default: begin
                h = sb2.hazard; b = sb2.branch; j = sb2.jump; f = sb2.flush;
                p = int'(sb2.pending_cnt); s = int'(sb2.stall_cycles);
            end
        endcase
    endfunction

    // Monitor: outputs are combinational, so sample mid-cycle or on an explicit request.
    always @(negedge clk or posedge sample_req) begin : monitor
        exp_t e;
        logic h, b, j, f;
        int   p, s;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_out(e.dut, h, b, j, f, p, s);
            n_checks++;
            if ({h, b, j, f} !== {e.hazard, e.branch, e.jump, e.flush} ||
                p != e.pend || s != e.stall) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got hazard=%b branch=%b jump=%b flush=%b pend=%0d stall=%0d, expected hazard=%b branch=%b jump=%b flush=%b pend=%0d stall=%0d",
                         e.name, e.dut, h, b, j, f, p, s,
                         e.hazard, e.branch, e.jump, e.flush, e.pend, e.stall);
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        sample_req = 1'b0;
        nrst = 1'b1;
        idle(0); idle(1); idle(2);
        #1 nrst = 1'b0;
        push(0, "reset0", 0, 0, 0, 0, 0, 0);
        push(1, "reset1", 0, 0, 0, 0, 0, 0);
        push(2, "reset2", 0, 0, 0, 0, 0, 0);
        #11 nrst = 1'b1;
        step();

        // Load-use with forwarding: one stall cycle, then the consumer issues.
        drive(0, LW, 1, 1, 1, 1, 0, 5, 0, 0);     push(0, "lw_issue", 0, 0, 0, 0, 0, 0); step();
        drive(0, RTYPE, 1, 1, 0, 5, 5, 6, 0, 0);  push(0, "load_use_stall", 1, 0, 0, 0, 1, 0);
        step();
        push(0, "load_use_release", 0, 0, 0, 0, 1, 1); step();
        idle(0);                                   push(0, "add_issued", 0, 0, 0, 0, 2, 1);
        repeat (3) step();

        // Memory freeze while a load-use stall and a jump sit in decode.
        drive(0, LW, 1, 1, 1, 1, 0, 5, 0, 0);     push(0, "mw_lw", 0, 0, 0, 0, 0, 1); step();
        for (int k = 0; k < 4; k++) begin
            if (k < 2) begin
                drive(0, RTYPE, 1, 1, 0, 5, 5, 6, 0, 1);
                push(0, "mw_stall", 1, 0, 0, 0, 1, 1);
            end else begin
                drive(0, J, 1, 0, 0, 5, 5, 0, 0, 1);
                push(0, "mw_jump", 0, 0, 1, 0, 1, 1);
            end
            step();
        end
        drive(0, RTYPE, 1, 1, 0, 5, 5, 6, 0, 0);  push(0, "mw_resume", 1, 0, 0, 0, 1, 1); step();
        push(0, "mw_release", 0, 0, 0, 0, 1, 2); step();
        drive(0, J, 1, 0, 0, 0, 0, 0, 0, 0);      push(0, "jump_flush", 0, 0, 1, 1, 2, 2); step();
        idle(0);
        repeat (3) step();

        // Branch masked by a pending load, taken once the hazard clears.
        drive(0, LW, 1, 1, 1, 1, 0, 7, 0, 0);     push(0, "br_lw", 0, 0, 0, 0, 0, 2); step();
        drive(0, BEQ, 1, 0, 0, 7, 2, 0, 1, 0);    push(0, "br_masked", 1, 0, 0, 0, 1, 2); step();
        push(0, "br_taken", 0, 1, 0, 1, 1, 3); step();
        drive(0, BNE, 1, 0, 0, 1, 2, 0, 0, 0);    push(0, "bne_taken", 0, 1, 0, 1, 1, 3); step();
        drive(0, BNE, 1, 0, 0, 1, 2, 0, 1, 0);    push(0, "bne_not", 0, 0, 0, 0, 0, 3); step();
        drive(0, BEQ, 1, 0, 0, 1, 2, 0, 0, 0);    push(0, "beq_not", 0, 0, 0, 0, 0, 3); step();
        idle(0);

        // No forwarding: consumer waits until the producer leaves the oldest slot.
        drive(1, RTYPE, 1, 1, 0, 1, 2, 3, 0, 0);  push(1, "nf_add", 0, 0, 0, 0, 0, 0); step();
        drive(1, RTYPE, 1, 1, 0, 3, 0, 4, 0, 0);  push(1, "nf_stall0", 1, 0, 0, 0, 1, 0); step();
        push(1, "nf_stall1", 1, 0, 0, 0, 1, 1); step();
        push(1, "nf_stall2", 1, 0, 0, 0, 1, 2); step();
        push(1, "nf_release", 0, 0, 0, 0, 0, 3); step();

        // Fill all three slots, then reset between edges.
        drive(1, RTYPE, 1, 1, 0, 1, 2, 8, 0, 0);  push(1, "d_r8", 0, 0, 0, 0, 1, 3); step();
        drive(1, RTYPE, 1, 1, 0, 1, 2, 9, 0, 0);  push(1, "d_r9", 0, 0, 0, 0, 2, 3); step();
        drive(1, RTYPE, 1, 1, 0, 9, 0, 10, 0, 0); push(1, "pre_reset", 1, 0, 0, 0, 3, 3);
        @(negedge clk);
        #1;
        nrst = 1'b0;
        drive(0, J, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        push(0, "rst_jump", 0, 0, 1, 1, 0, 0);
        push(1, "rst_clear", 0, 0, 0, 0, 0, 0);
        push(2, "rst_idle", 0, 0, 0, 0, 0, 0);
        sample_req = 1'b1;
        #1 sample_req = 1'b0;
        @(posedge clk);
        #3;
        nrst = 1'b1;
        idle(0); idle(1);
        step();

        // Writes to r0 are never tracked.
        drive(1, RTYPE, 1, 1, 0, 1, 2, 0, 0, 0);  push(1, "r0_write", 0, 0, 0, 0, 0, 0); step();
        drive(1, RTYPE, 1, 0, 0, 0, 0, 4, 0, 0);  push(1, "r0_none", 0, 0, 0, 0, 0, 0); step();
        idle(1);

        // Saturation: add r3,r3,r3 held in decode stalls 8 of every 9 cycles at depth 8.
        drive(2, RTYPE, 1, 1, 0, 3, 3, 3, 0, 0);
        for (int it = 0; it < 8750; it++) begin
            for (int c = 0; c < 9; c++) begin
                if (it == 0 && c == 0) push(2, "sat_c0", 0, 0, 0, 0, 0, 0);
                if (it == 0 && c == 1) push(2, "sat_c1", 1, 0, 0, 0, 1, 0);
                if (it == 0 && c == 8) push(2, "sat_c8", 1, 0, 0, 0, 1, 7);
                if (it == 1 && c == 0) push(2, "sat_iter1", 0, 0, 0, 0, 0, 8);
                step();
            end
        end
        push(2, "sat_final", 0, 0, 0, 0, 0, 65535);
        @(negedge clk);
        #1;
        idle(2);
        repeat (2) @(negedge clk);
        #1;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32: architectural register count; register 0 never creates a hazard.
REQ-002 SHALL have parameter DEPTH, default 3: in-flight stages tracked between decode and writeback; legal range 1..8.
REQ-003 SHALL have parameter FWD_EN, default 1: 1 stalls only on load-use; 0 stalls on any pending write.
REQ-004 SHALL have port CLK  in  1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port nRST  in  1: asynchronous, active-low reset.
REQ-006 SHALL have ports id_rsel1, id_rsel2  in  $clog2(NREGS) each: decode-stage source registers.
REQ-007 SHALL have port id_wsel  in  $clog2(NREGS): decode-stage destination register.
REQ-008 SHALL have ports id_wen, id_load, id_valid  in  1 each: writes a register; is a load; decode slot holds a real instruction.
REQ-009 SHALL have port id_op  in  opcode_t: decode-stage opcode.
REQ-010 SHALL have port id_equal  in  1: decode-stage register comparator result.
REQ-011 SHALL have port mem_wait  in  1: pipeline-wide freeze from the memory system.
REQ-012 SHALL have ports hazard, branch, jump, flush  out  1 each: stall decode; taken branch; jump; squash fetch.
REQ-013 SHALL have port pending_cnt  out  $clog2(DEPTH+1): number of valid scoreboard entries.
REQ-014 SHALL have port stall_cycles  out  16: saturating count of cycles with hazard=1 and mem_wait=0.

Function
REQ-015 SHALL hold DEPTH entries {valid, wsel, load}; entry 0 is the youngest, entry DEPTH-1 the oldest.
REQ-016 SHALL shift every entry one position older on each edge with mem_wait=0; entry DEPTH-1 retires.
REQ-017 SHALL load entry 0 with {1, id_wsel, id_load} when id_valid & id_wen & id_wsel!=0 & !hazard & !flush; otherwise it loads a bubble (valid=0).
REQ-018 SHALL hold all entries, pending_cnt and stall_cycles unchanged on every edge with mem_wait=1.
REQ-019 SHALL assert hazard combinationally when id_valid=1 and a nonzero id_rsel1 or id_rsel2 equals wsel of a matching valid entry.
REQ-020 SHALL treat an entry as matching as follows: FWD_EN=0, any valid entry; FWD_EN=1, entry 0 only, and only when its load=1.
REQ-021 SHALL force hazard=0 when id_op is J or JAL, because those opcodes read no registers.
REQ-022 SHALL assert branch when (id_op=BEQ & id_equal) or (id_op=BNE & !id_equal), and only when hazard=0.
REQ-023 SHALL assert jump when id_op is J or JAL, regardless of hazard.
REQ-024 SHALL assert flush = (branch | jump) & !mem_wait.
REQ-025 SHALL drive pending_cnt as the population count of valid entries; it SHALL never exceed DEPTH.
REQ-026 SHALL increment stall_cycles by 1 on each qualifying cycle and hold it at 16'hFFFF once reached, with no wrap.
REQ-027 SHALL let an entry retiring on the same edge as a new match still cause hazard in that cycle, because evaluation uses pre-edge state.
REQ-028 SHALL make all outputs combinational from current state and inputs; there is zero-cycle latency from inputs to hazard, branch, jump and flush.

Reset
REQ-029 SHALL, while nRST=0, asynchronously clear every entry's valid bit, pending_cnt and stall_cycles.
REQ-030 SHALL, with nRST=0 and all entries invalid, drive hazard=0; branch, jump and flush SHALL follow only id_op and id_equal.
REQ-031 SHALL discard all in-flight entries when reset is asserted mid-operation, with no partial shift.

Structure
REQ-032 SHALL add typedef sb_entry_t {logic valid; regbits_t wsel; logic load;} to cpu_types_pkg; opcode_t and regbits_t SHALL come from cpu_types_pkg.
REQ-033 SHALL place the per-source compare in one combinational sub-module, hazard_match, instantiated twice (rsel1, rsel2).
REQ-034 SHALL contain no constants other than the parameters and package types.

Verification
REQ-035 SHALL cover load-use, FWD_EN=1: lw r5 then add r6,r5,r5 -> hazard=1 for exactly 1 cycle, bubble enters, stall_cycles=1.
REQ-036 SHALL cover no forwarding, FWD_EN=0, DEPTH=3: add r3 then sub r4,r3,r0 -> hazard=1 for 3 cycles, then 0.
REQ-037 SHALL cover mem_wait during a stall: hold mem_wait=1 for 4 cycles with lw r5 in entry 0 -> entries, pending_cnt and stall_cycles frozen; flush=0 while a jump is decoded.
REQ-038 SHALL cover branch masking: BEQ, id_equal=1, rsel1 matches a pending load -> branch=0 and flush=0; the next cycle with no hazard -> branch=1 and flush=1.
REQ-039 SHALL cover reset mid-flight: pending_cnt=3, drive nRST low asynchronously between edges -> pending_cnt=0 and hazard=0 immediately.
REQ-040 SHALL cover saturation: force 70000 stall cycles -> stall_cycles=16'hFFFF; writes to r0 never set valid.
